// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
//
// Shares one UART byte transmitter between NREQ requesters. Ownership is
// granted round-robin and held for a whole packet: the owner keeps sending
// bytes until it flags i_last or drops its request. Only then is the
// transmitter re-arbitrated. A transmitter handshake of start pulse, ready
// low, then ready high paces each byte.
//
// Parameters
//   NREQ        number of requesters (2..8)
//   CLOG        pointer width, ceil(log2(NREQ))
//
// Ports
//   clk         system clock, rising edge
//   rstn        asynchronous active-low reset
//   i_req       per-requester byte valid, bit k = requester k
//   i_data      per-requester byte, requester k on [8k+7:8k]
//   i_last      per-requester end-of-packet flag, qualified by i_req
//   o_ack       one-cycle pulse: byte of requester k consumed
//   o_grant     one-hot current owner, zero when nobody owns the link
//   o_tx_start  one-cycle start pulse to the transmitter
//   o_tx_data   byte to the transmitter; holds the last issued byte
//   i_tx_ready  transmitter idle flag
//   o_busy      high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module uart_tx_arb #(
    parameter int NREQ = 4,
    parameter int CLOG = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   i_req,
    input  logic [8*NREQ-1:0] i_data,
    input  logic [NREQ-1:0]   i_last,
    output logic [NREQ-1:0]   o_ack,
    output logic [NREQ-1:0]   o_grant,
    output logic              o_tx_start,
    output logic [7:0]        o_tx_data,
    input  logic              i_tx_ready,
    output logic              o_busy
);

    // One-hot state encoding.
    localparam logic [3:0] S_IDLE      = 4'b0001;
    localparam logic [3:0] S_ISSUE     = 4'b0010;
    localparam logic [3:0] S_WAIT_BUSY = 4'b0100;
    localparam logic [3:0] S_WAIT_DONE = 4'b1000;

    localparam logic [CLOG:0]   NREQ_W    = (CLOG+1)'(NREQ);
    localparam logic [CLOG-1:0] LAST_IDX  = CLOG'(NREQ-1);
    localparam logic [NREQ-1:0] ONE_VEC   = {{(NREQ-1){1'b0}}, 1'b1};

    logic [3:0]      r_state;
    logic [3:0]      w_next;
    logic [CLOG-1:0] r_owner;
    logic [CLOG-1:0] r_last_owner;
    logic            r_last_q;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] r_ack;
    logic            r_tx_start;
    logic [7:0]      r_tx_data;

    logic [CLOG-1:0] w_pick;
    logic            w_found;
    logic [CLOG:0]   w_sum;
    logic [CLOG-1:0] w_issue_owner;
    logic            w_legal;
    logic            w_pkt_end;

    // Round-robin search: start one past the previous packet owner and walk
    // upward with wrap-around; the first requester found wins. The sum is one
    // bit wider than the pointer so the wrap is a single conditional subtract.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        w_sum   = '0;
        for (int off = 1; off <= NREQ; off++) begin
            w_sum = {1'b0, r_last_owner} + (CLOG+1)'(off);
            if (w_sum >= NREQ_W) begin
                w_sum = w_sum - NREQ_W;
            end
            if (!w_found && i_req[w_sum[CLOG-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[CLOG-1:0];
            end
        end
    end

    // A packet closes when the transmitter returns to idle and the owner
    // either marked its last byte or has stopped requesting (abandoned).
    assign w_pkt_end = (r_state == S_WAIT_DONE) && i_tx_ready &&
                       (r_last_q || !i_req[r_owner]);

    // From IDLE the owner is the freshly arbitrated winner; from WAIT_DONE
    // the packet continues with the existing owner.
    assign w_issue_owner = (r_state == S_IDLE) ? w_pick : r_owner;

    assign w_legal = (r_state == S_IDLE)      || (r_state == S_ISSUE) ||
                     (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);

    // Next-state logic. Any encoding outside the four legal one-hot codes
    // falls back to IDLE on the following edge.
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_found && i_tx_ready) begin
                    w_next = S_ISSUE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ISSUE: begin
                w_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!i_tx_ready) begin
                    w_next = S_WAIT_DONE;
                end else begin
                    w_next = S_WAIT_BUSY;
                end
            end
            S_WAIT_DONE: begin
                if (!i_tx_ready) begin
                    w_next = S_WAIT_DONE;
                end else if (!r_last_q && i_req[r_owner]) begin
                    w_next = S_ISSUE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Issue path. Start, ack, data and the last flag are all loaded on the
    // edge that enters ISSUE, so they are valid together for exactly the one
    // ISSUE cycle. The data register is left alone otherwise so the
    // transmitter always sees the last issued byte.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tx_start <= 1'b0;
            r_ack      <= '0;
            r_tx_data  <= 8'h00;
            r_last_q   <= 1'b0;
            r_owner    <= '0;
        end else if (w_next == S_ISSUE) begin
            r_tx_start <= 1'b1;
            r_ack      <= ONE_VEC << w_issue_owner;
            r_tx_data  <= i_data[{w_issue_owner, 3'b000} +: 8];
            r_last_q   <= i_last[w_issue_owner];
            r_owner    <= w_issue_owner;
        end else begin
            r_tx_start <= 1'b0;
            r_ack      <= '0;
        end
    end

    // Grant and fairness pointer. The grant is set on entry to ISSUE from
    // IDLE and held across every byte of the packet; the pointer moves only
    // when a packet finishes, so a multi-byte packet counts as one turn.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_grant      <= '0;
            r_last_owner <= LAST_IDX;
        end else if (!w_legal) begin
            r_grant <= '0;
        end else if ((r_state == S_IDLE) && (w_next == S_ISSUE)) begin
            r_grant <= ONE_VEC << w_pick;
        end else if (w_pkt_end) begin
            r_grant      <= '0;
            r_last_owner <= r_owner;
        end
    end

    assign o_tx_start = r_tx_start;
    assign o_ack      = r_ack;
    assign o_tx_data  = r_tx_data;
    assign o_grant    = r_grant;
    // An illegal state code must not look busy to the outside world.
    assign o_busy     = w_legal && (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arb
//
// Directed bench for uart_tx_arb with NREQ=4. A small transmitter model
// drops i_tx_ready on the edge after it sees a start and raises it again
// txLen cycles later; holdBusy forces it low independently.
// ---------------------------------------------------------------------------
module tb_uart_tx_arb;

    localparam int NREQ = 4;
    localparam int CLOG = 2;

    logic              clk;
    logic              rstn;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] data;
    logic [NREQ-1:0]   last;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   grant;
    logic              txStart;
    logic [7:0]        txData;
    logic              txReady;
    logic              busy;

    int compared   = 0;
    int mismatched = 0;
    int txLen      = 4;
    int txCnt;
    logic holdBusy;

    uart_tx_arb #(.NREQ(NREQ), .CLOG(CLOG)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_req      (req),
        .i_data     (data),
        .i_last     (last),
        .o_ack      (ack),
        .o_grant    (grant),
        .o_tx_start (txStart),
        .o_tx_data  (txData),
        .i_tx_ready (txReady),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: busy for txLen cycles after accepting a start.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            txCnt <= 0;
        end else if (txStart) begin
            txCnt <= txLen;
        end else if (txCnt > 0) begin
            txCnt <= txCnt - 1;
        end
    end
    assign txReady = (txCnt == 0) && !holdBusy;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [31:0] d,
                                 input logic [NREQ-1:0] l);
        req  = r;
        data = d;
        last = l;
    endtask

    // Steps negedges until a start pulse appears; cyc returns the distance.
    task automatic waitStart(input string tag, input int maxCyc, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!txStart && cyc < maxCyc);
        checkOutput(tag, {31'd0, txStart}, 32'd1);
    endtask

    task automatic waitIdle(input string tag, input int maxCyc, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (busy && cyc < maxCyc);
        checkOutput(tag, {31'd0, busy}, 32'd0);
    endtask

    int cyc;
    int badStart, badAck, notBusy, starts;
    logic [7:0]      fairData [5];
    logic [NREQ-1:0] fairGrant [5];

    initial begin
        fairData  = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
        fairGrant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        holdBusy = 1'b0;
        rstn = 1'b0;
        applyStimulus(4'b0000, 32'h0, 4'b0000);

        // Reset values.
        repeat (2) @(negedge clk);
        checkOutput("rst_grant", {28'd0, grant}, 32'h0);
        checkOutput("rst_ack", {28'd0, ack}, 32'h0);
        checkOutput("rst_start", {31'd0, txStart}, 32'h0);
        checkOutput("rst_data", {24'd0, txData}, 32'h0);
        checkOutput("rst_busy", {31'd0, busy}, 32'h0);

        // Single byte from requester 2.
        applyStimulus(4'b0100, 32'h00A5_0000, 4'b0100);
        rstn = 1'b1;
        waitStart("single_start", 20, cyc);
        checkOutput("single_data", {24'd0, txData}, 32'hA5);
        checkOutput("single_ack", {28'd0, ack}, 32'h4);
        checkOutput("single_grant", {28'd0, grant}, 32'h4);
        req = 4'b0000;
        @(negedge clk);
        checkOutput("single_start_pulse", {31'd0, txStart}, 32'h0);
        checkOutput("single_ack_pulse", {28'd0, ack}, 32'h0);
        checkOutput("single_grant_hold", {28'd0, grant}, 32'h4);
        waitIdle("single_idle", 30, cyc);
        checkOutput("single_idle_cycles", cyc, 32'd5);
        checkOutput("single_grant_clear", {28'd0, grant}, 32'h0);
        checkOutput("single_data_hold", {24'd0, txData}, 32'hA5);

        // Fairness from a fresh reset: order 0,1,2,3,0.
        rstn = 1'b0;
        @(negedge clk);
        applyStimulus(4'b1111, 32'h4332_2110, 4'b1111);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            waitStart($sformatf("fair%0d_start", i), 30, cyc);
            checkOutput($sformatf("fair%0d_data", i), {24'd0, txData}, {24'd0, fairData[i]});
            checkOutput($sformatf("fair%0d_grant", i), {28'd0, grant}, {28'd0, fairGrant[i]});
        end
        req = 4'b0000;
        waitIdle("fair_idle", 30, cyc);

        // Packet hold: requester 1 sends three bytes while requester 3 waits.
        applyStimulus(4'b1010, 32'hD300_B000, 4'b1000);
        waitStart("hold_b0_start", 30, cyc);
        checkOutput("hold_b0_data", {24'd0, txData}, 32'hB0);
        checkOutput("hold_b0_grant", {28'd0, grant}, 32'h2);
        data[15:8] = 8'hB1;
        waitStart("hold_b1_start", 30, cyc);
        checkOutput("hold_b1_spacing", cyc, 32'd6);
        checkOutput("hold_b1_data", {24'd0, txData}, 32'hB1);
        checkOutput("hold_b1_grant", {28'd0, grant}, 32'h2);
        data[15:8] = 8'hB2;
        last[1] = 1'b1;
        waitStart("hold_b2_start", 30, cyc);
        checkOutput("hold_b2_data", {24'd0, txData}, 32'hB2);
        checkOutput("hold_b2_ack", {28'd0, ack}, 32'h2);
        req[1] = 1'b0;
        waitStart("hold_r3_start", 30, cyc);
        checkOutput("hold_r3_data", {24'd0, txData}, 32'hD3);
        checkOutput("hold_r3_grant", {28'd0, grant}, 32'h8);
        req = 4'b0000;
        waitIdle("hold_idle", 30, cyc);

        // Abandon: requester 0 drops after one non-last byte.
        applyStimulus(4'b0011, 32'h0000_C1C0, 4'b0010);
        waitStart("abandon_r0_start", 30, cyc);
        checkOutput("abandon_r0_data", {24'd0, txData}, 32'hC0);
        checkOutput("abandon_r0_grant", {28'd0, grant}, 32'h1);
        req[0] = 1'b0;
        waitStart("abandon_r1_start", 30, cyc);
        checkOutput("abandon_r1_spacing", cyc, 32'd7);
        checkOutput("abandon_r1_data", {24'd0, txData}, 32'hC1);
        checkOutput("abandon_r1_grant", {28'd0, grant}, 32'h2);
        req = 4'b0000;
        waitIdle("abandon_idle", 30, cyc);

        // Slow transmitter: ready low for 20 cycles after the start.
        txLen = 20;
        applyStimulus(4'b0100, 32'h005A_0000, 4'b0100);
        waitStart("slow_start", 30, cyc);
        badStart = 0;
        badAck   = 0;
        notBusy  = 0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            if (txStart) badStart++;
            if (ack != '0) badAck++;
            if (!busy) notBusy++;
        end
        checkOutput("slow_no_start", badStart, 32'd0);
        checkOutput("slow_no_ack", badAck, 32'd0);
        checkOutput("slow_busy", notBusy, 32'd0);
        req = 4'b0000;
        waitIdle("slow_idle", 10, cyc);
        checkOutput("slow_idle_cycles", cyc, 32'd1);
        txLen = 4;

        // Transmitter busy while idle: no arbitration until ready returns.
        holdBusy = 1'b1;
        applyStimulus(4'b0001, 32'h0000_0099, 4'b0001);
        badStart = 0;
        notBusy  = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (txStart) badStart++;
            if (busy) notBusy++;
        end
        checkOutput("notready_no_start", badStart, 32'd0);
        checkOutput("notready_idle", notBusy, 32'd0);
        holdBusy = 1'b0;
        waitStart("notready_start", 10, cyc);
        checkOutput("notready_latency", cyc, 32'd1);
        checkOutput("notready_grant", {28'd0, grant}, 32'h1);
        req = 4'b0000;
        waitIdle("notready_idle_end", 30, cyc);

        // Reset in the middle of a packet.
        applyStimulus(4'b0001, 32'h0000_0077, 4'b0000);
        waitStart("midrst_start", 30, cyc);
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        checkOutput("midrst_grant", {28'd0, grant}, 32'h0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'h0);
        checkOutput("midrst_data", {24'd0, txData}, 32'h0);
        checkOutput("midrst_ack", {28'd0, ack}, 32'h0);
        @(negedge clk);
        applyStimulus(4'b1000, 32'h3C00_0000, 4'b1000);
        rstn = 1'b1;
        waitStart("midrst_new_start", 10, cyc);
        checkOutput("midrst_new_latency", cyc, 32'd1);
        checkOutput("midrst_new_grant", {28'd0, grant}, 32'h8);
        checkOutput("midrst_new_data", {24'd0, txData}, 32'h3C);
        req = 4'b0000;
        starts = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (txStart) starts++;
        end
        checkOutput("midrst_single_start", starts, 32'd0);
        checkOutput("midrst_final_busy", {31'd0, busy}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one UART transmitter (legal 2..8).
REQ-002 Parameter CLOG, default 2, pointer width; SHALL equal ceil(log2(NREQ)).
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 i_req  input  NREQ  per-requester byte valid; bit k belongs to requester k.
REQ-006 i_data  input  8*NREQ  per-requester byte; requester k on bits [8k+7:8k].
REQ-007 i_last  input  NREQ  per-requester end-of-packet flag, qualified by i_req.
REQ-008 o_ack  output  NREQ  one-cycle pulse; byte of requester k consumed.
REQ-009 o_grant  output  NREQ  one-hot current owner; all-zero when no owner.
REQ-010 o_tx_start  output  1  one-cycle start pulse to transmitter.
REQ-011 o_tx_data  output  8  byte to transmitter, valid with o_tx_start.
REQ-012 i_tx_ready  input  1  transmitter idle flag; drops one cycle after an accepted start.
REQ-013 o_busy  output  1  high in any state other than IDLE.

Function
REQ-014 States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE; one-hot encoding; illegal state -> IDLE next cycle, outputs deasserted.
REQ-015 IDLE: if any i_req bit high and i_tx_ready=1 -> select owner by round-robin, go ISSUE; else stay.
REQ-016 Round-robin: search starts at index (last_owner+1) mod NREQ, ascending with wrap; first set i_req bit wins.
REQ-017 last_owner updates only at packet end (REQ-022); reset value NREQ-1, so requester 0 wins the first arbitration.
REQ-018 ISSUE (1 cycle): o_tx_start=1, o_tx_data=owner's i_data, o_ack[owner]=1; owner's i_last captured into last_q; -> WAIT_BUSY.
REQ-019 o_tx_data registered; SHALL hold last issued byte between starts.
REQ-020 WAIT_BUSY: wait for i_tx_ready=0, then -> WAIT_DONE; no timeout.
REQ-021 WAIT_DONE: wait for i_tx_ready=1; then if last_q=0 and i_req[owner]=1 -> ISSUE same owner (packet held).
REQ-022 WAIT_DONE with i_tx_ready=1 and (last_q=1 or i_req[owner]=0): packet ends; last_owner<=owner; o_grant<=0; -> IDLE.
REQ-023 Owner with last_q=0 that drops i_req loses grant (abandoned packet); no error flag.
REQ-024 o_grant set in the cycle entering ISSUE from IDLE, held through the packet; at most one bit ever set.
REQ-025 o_ack at most one bit high, at most once per byte; never while i_tx_ready=0.
REQ-026 Requests arriving mid-packet wait; requests of non-owners never preempt.
REQ-027 i_data/i_last of non-owners ignored; owner's i_data sampled only in ISSUE.
REQ-028 Minimum spacing between o_tx_start pulses: 3 cycles (ISSUE, WAIT_BUSY, WAIT_DONE).
REQ-029 i_tx_ready=0 in IDLE (transmitter still busy): no arbitration, no ack.

Reset
REQ-030 rstn low asynchronously forces: state IDLE, o_ack=0, o_grant=0, o_tx_start=0, o_tx_data=8'h00, o_busy=0, last_q=0, last_owner=NREQ-1.
REQ-031 Reset mid-packet discards the packet; after release, arbitration restarts from requester 0; no spurious o_tx_start in the release cycle.

Verification
REQ-032 Single byte: i_req=4'b0100, i_data[23:16]=8'hA5, i_last[2]=1, ready model -> one o_tx_start with 8'hA5, o_ack=4'b0100 same cycle, o_grant=4'b0100 until ready returns, then IDLE.
REQ-033 Fairness: i_req=4'b1111 all single-byte, held -> grant order 0,1,2,3,0 with 8'h10,8'h21,8'h32,8'h43 on o_tx_data.
REQ-034 Packet hold: requester 1 sends 3 bytes (last on 3rd) while requester 3 requests -> three consecutive starts for requester 1 before any grant to 3.
REQ-035 Abandon: requester 0 drops i_req after byte 1 with i_last=0 -> grant returns to zero after ready; next winner is requester 1 if requesting.
REQ-036 Slow transmitter: i_tx_ready held low 20 cycles after start -> no new start, no ack, o_busy=1 throughout.
REQ-037 Reset mid-packet: rstn low during WAIT_DONE -> all outputs at reset values immediately; after release with i_req=4'b1000, first grant 4'b1000 and a single start.
